otter_fetch_queue: RTL and testbench

OTTER_FETCH_QUEUE -- requirements
Module: otter_fetch_queue

---
 rtl/otter_fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/otter_fetch_queue.sv | 98 +++++++++
 tb/tb_otter_fetch_queue.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_fetch_pkg.sv
// +----------------------------------------------------------------+
// | otter_fetch_pkg: shared types and defaults for the fetch queue  |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
`default_nettype none

package otter_fetch_pkg;

  localparam int FETCH_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// +----------------------------------------------------------------+
// | fetch_fifo: generic synchronous FIFO with clear, full and empty |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
`default_nettype none

module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_CNT_W'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign dout      = r_mem[r_rptr];
  assign count     = r_count;

  // Clear only rewinds pointers; storage contents are left as-is.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= din;
        r_wptr        <= r_wptr + c_PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + c_PTR_W'(1);
      end
      r_count <= r_count + c_CNT_W'(w_do_push) - c_CNT_W'(w_do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/otter_fetch_queue.sv
// +----------------------------------------------------------------+
// | otter_fetch_queue: instruction fetch with decoupling queue      |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
`default_nettype none

module otter_fetch_queue
  import otter_fetch_pkg::*;
#(
  parameter int          DEPTH    = FETCH_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        MEM_READ1,
  output logic [31:0] MEM_ADDR1,
  input  logic [31:0] MEM_DOUT1,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  input  logic        DE_READY,
  output logic        DE_VALID,
  output logic [31:0] DE_IR,
  output logic [31:0] DE_PC,
  output logic [31:0] DE_PCPLUS4
);

  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]        r_fpc;
  logic [31:0]        r_req_pc;
  logic               r_inflight;
  logic [c_CNT_W-1:0] w_count;
  logic [c_CNT_W:0]   w_occupancy;
  logic [31:0]        w_redirect_target;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  fetch_entry_t       w_wr_entry;
  fetch_entry_t       w_head;

  // Outstanding response reserves a slot; same-cycle pops do not free one.
  assign w_occupancy       = {1'b0, w_count} + {{c_CNT_W{1'b0}}, r_inflight};
  assign w_issue           = RST_N & ~REDIRECT & ~w_full
                           & (w_occupancy < (c_CNT_W + 1)'(DEPTH));
  assign w_redirect_target = REDIRECT_PC & ~32'h3;

  assign MEM_READ1 = w_issue;
  assign MEM_ADDR1 = r_fpc;

  assign w_push        = r_inflight & ~REDIRECT;
  assign w_pop         = DE_VALID & DE_READY & ~REDIRECT;
  assign w_wr_entry.pc = r_req_pc;
  assign w_wr_entry.ir = MEM_DOUT1;

  assign DE_VALID   = ~w_empty;
  assign DE_IR      = w_head.ir;
  assign DE_PC      = w_head.pc;
  assign DE_PCPLUS4 = w_head.pc + 32'd4;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_fpc      <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_req_pc <= r_fpc;
      end
      if (REDIRECT) begin
        r_fpc <= w_redirect_target;
      end else if (w_issue) begin
        r_fpc <= r_fpc + 32'd4;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (w_push),
    .pop   (w_pop),
    .clear (REDIRECT),
    .din   (w_wr_entry),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_otter_fetch_queue.sv
// +----------------------------------------------------------------+
// | tb_otter_fetch_queue: directed self-checking bench              |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
`default_nettype none

module tb_otter_fetch_queue;

  localparam logic [31:0] c_KEY = 32'hA5A5A5A5;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        MEM_READ1;
  logic [31:0] MEM_ADDR1;
  logic [31:0] MEM_DOUT1 = 32'h0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = 32'h0;
  logic        DE_READY = 1'b0;
  logic        DE_VALID;
  logic [31:0] DE_IR;
  logic [31:0] DE_PC;
  logic [31:0] DE_PCPLUS4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  // Memory answers one cycle after the strobe; unrequested cycles return junk.
  always @(posedge CLK) MEM_DOUT1 <= MEM_READ1 ? (MEM_ADDR1 ^ c_KEY) : 32'hBAD0BAD0;

  otter_fetch_queue dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .MEM_READ1   (MEM_READ1),
    .MEM_ADDR1   (MEM_ADDR1),
    .MEM_DOUT1   (MEM_DOUT1),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .DE_READY    (DE_READY),
    .DE_VALID    (DE_VALID),
    .DE_IR       (DE_IR),
    .DE_PC       (DE_PC),
    .DE_PCPLUS4  (DE_PCPLUS4)
  );

  task automatic next_cycle;
    @(posedge CLK);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle 0 (first cycle with RST_N high).
  task automatic apply_reset;
    RST_N = 1'b0;
    REDIRECT = 1'b0;
    next_cycle();
    RST_N = 1'b1;
  endtask

  task automatic test_reset;
    DE_READY = 1'b0;
    RST_N = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge CLK);
    n_checks++; if (DE_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%h exp=0", DE_VALID); end
    n_checks++; if (MEM_READ1 !== 1'b0) begin n_fail++; $display("FAIL reset_read got=%h exp=0", MEM_READ1); end
    n_checks++; if (DE_IR !== 32'h0) begin n_fail++; $display("FAIL reset_ir got=%h exp=0", DE_IR); end
    n_checks++; if (DE_PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", DE_PC); end
    n_checks++; if (DE_PCPLUS4 !== 32'h4) begin n_fail++; $display("FAIL reset_pcplus4 got=%h exp=4", DE_PCPLUS4); end
    n_checks++; if (MEM_ADDR1 !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", MEM_ADDR1); end
  endtask

  task automatic test_stream;
    logic [31:0] exp_pc;
    DE_READY = 1'b1;
    next_cycle();
    RST_N = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        n_checks++; if (MEM_READ1 !== 1'b1 || MEM_ADDR1 !== 32'h0) begin
          n_fail++; $display("FAIL stream_first_req read=%h addr=%h exp read=1 addr=0", MEM_READ1, MEM_ADDR1);
        end
      end
      n_checks++; if (DE_VALID !== (k >= 2)) begin
        n_fail++; $display("FAIL stream_valid k=%0d got=%h exp=%h", k, DE_VALID, (k >= 2));
      end
      if (k >= 2) begin
        exp_pc = 32'(4 * (k - 2));
        n_checks++; if (DE_PC !== exp_pc || DE_IR !== (exp_pc ^ c_KEY) || DE_PCPLUS4 !== exp_pc + 32'd4) begin
          n_fail++; $display("FAIL stream_head k=%0d pc=%h ir=%h p4=%h exp pc=%h", k, DE_PC, DE_IR, DE_PCPLUS4, exp_pc);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_pc;
    logic        exp_rd;
    DE_READY = 1'b0;
    apply_reset();
    for (int k = 0; k < 18; k++) begin
      if (k == 10) DE_READY = 1'b1;
      @(negedge CLK);
      exp_rd = (k < 4) || (k >= 11);
      n_checks++; if (MEM_READ1 !== exp_rd) begin
        n_fail++; $display("FAIL bp_read k=%0d got=%h exp=%h", k, MEM_READ1, exp_rd);
      end
      n_checks++; if (DE_VALID !== (k >= 2)) begin
        n_fail++; $display("FAIL bp_valid k=%0d got=%h exp=%h", k, DE_VALID, (k >= 2));
      end
      if (k >= 2) begin
        exp_pc = (k < 10) ? 32'h0 : 32'(4 * (k - 10));
        n_checks++; if (DE_PC !== exp_pc || DE_IR !== (exp_pc ^ c_KEY)) begin
          n_fail++; $display("FAIL bp_head k=%0d pc=%h ir=%h exp pc=%h", k, DE_PC, DE_IR, exp_pc);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect;
    logic [31:0] exp_pc;
    DE_READY = 1'b0;
    apply_reset();
    for (int k = 0; k < 11; k++) begin
      if (k == 4) begin
        REDIRECT = 1'b1; REDIRECT_PC = 32'h100; DE_READY = 1'b1;
      end
      if (k == 5) REDIRECT = 1'b0;
      @(negedge CLK);
      if (k == 4) begin
        n_checks++; if (MEM_READ1 !== 1'b0 || DE_VALID !== 1'b1 || DE_PC !== 32'h0) begin
          n_fail++; $display("FAIL redir_cycle read=%h valid=%h pc=%h exp read=0 valid=1 pc=0", MEM_READ1, DE_VALID, DE_PC);
        end
      end
      if (k == 5) begin
        n_checks++; if (MEM_READ1 !== 1'b1 || MEM_ADDR1 !== 32'h100) begin
          n_fail++; $display("FAIL redir_req read=%h addr=%h exp read=1 addr=100", MEM_READ1, MEM_ADDR1);
        end
      end
      if (k == 5 || k == 6) begin
        n_checks++; if (DE_VALID !== 1'b0) begin
          n_fail++; $display("FAIL redir_gap k=%0d valid=%h pc=%h exp valid=0", k, DE_VALID, DE_PC);
        end
      end
      if (k >= 7) begin
        exp_pc = 32'h100 + 32'(4 * (k - 7));
        n_checks++; if (DE_VALID !== 1'b1 || DE_PC !== exp_pc || DE_IR !== (exp_pc ^ c_KEY)) begin
          n_fail++; $display("FAIL redir_head k=%0d valid=%h pc=%h ir=%h exp pc=%h", k, DE_VALID, DE_PC, DE_IR, exp_pc);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_align;
    DE_READY = 1'b1;
    REDIRECT = 1'b1; REDIRECT_PC = 32'h203;
    @(negedge CLK);
    n_checks++; if (MEM_READ1 !== 1'b0) begin n_fail++; $display("FAIL align_hold got=%h exp=0", MEM_READ1); end
    next_cycle();
    REDIRECT = 1'b0;
    @(negedge CLK);
    n_checks++; if (MEM_READ1 !== 1'b1 || MEM_ADDR1 !== 32'h200) begin
      n_fail++; $display("FAIL align_addr read=%h addr=%h exp read=1 addr=200", MEM_READ1, MEM_ADDR1);
    end
    next_cycle();
    next_cycle();
    @(negedge CLK);
    n_checks++; if (DE_VALID !== 1'b1 || DE_PC !== 32'h200 || DE_IR !== (32'h200 ^ c_KEY)) begin
      n_fail++; $display("FAIL align_head valid=%h pc=%h ir=%h exp pc=200", DE_VALID, DE_PC, DE_IR);
    end
    next_cycle();
  endtask

  task automatic test_wrap;
    DE_READY = 1'b1;
    REDIRECT = 1'b1; REDIRECT_PC = 32'h40;
    @(negedge CLK);
    n_checks++; if (MEM_READ1 !== 1'b0) begin n_fail++; $display("FAIL wrap_hold0 got=%h exp=0", MEM_READ1); end
    next_cycle();
    REDIRECT_PC = 32'hFFFFFFFF;
    @(negedge CLK);
    n_checks++; if (MEM_READ1 !== 1'b0 || DE_VALID !== 1'b0) begin
      n_fail++; $display("FAIL wrap_hold1 read=%h valid=%h exp 0 0", MEM_READ1, DE_VALID);
    end
    next_cycle();
    REDIRECT = 1'b0;
    @(negedge CLK);
    n_checks++; if (MEM_READ1 !== 1'b1 || MEM_ADDR1 !== 32'hFFFFFFFC) begin
      n_fail++; $display("FAIL wrap_req0 read=%h addr=%h exp read=1 addr=fffffffc", MEM_READ1, MEM_ADDR1);
    end
    next_cycle();
    @(negedge CLK);
    n_checks++; if (MEM_ADDR1 !== 32'h0 || DE_VALID !== 1'b0) begin
      n_fail++; $display("FAIL wrap_req1 addr=%h valid=%h exp addr=0 valid=0", MEM_ADDR1, DE_VALID);
    end
    next_cycle();
    @(negedge CLK);
    n_checks++; if (DE_VALID !== 1'b1 || DE_PC !== 32'hFFFFFFFC || DE_PCPLUS4 !== 32'h0 || DE_IR !== 32'h5A5A5A59) begin
      n_fail++; $display("FAIL wrap_head0 valid=%h pc=%h p4=%h ir=%h exp pc=fffffffc p4=0 ir=5a5a5a59", DE_VALID, DE_PC, DE_PCPLUS4, DE_IR);
    end
    next_cycle();
    @(negedge CLK);
    n_checks++; if (DE_VALID !== 1'b1 || DE_PC !== 32'h0 || DE_PCPLUS4 !== 32'h4 || DE_IR !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL wrap_head1 valid=%h pc=%h p4=%h ir=%h exp pc=0 p4=4 ir=a5a5a5a5", DE_VALID, DE_PC, DE_PCPLUS4, DE_IR);
    end
    next_cycle();
  endtask

  task automatic test_async_reset;
    DE_READY = 1'b1;
    REDIRECT = 1'b1; REDIRECT_PC = 32'h80;
    next_cycle();
    REDIRECT = 1'b0;
    repeat (5) next_cycle();
    n_checks++; if (DE_VALID !== 1'b1 || MEM_ADDR1 === 32'h0) begin
      n_fail++; $display("FAIL areset_pre valid=%h addr=%h exp valid=1 addr!=0", DE_VALID, MEM_ADDR1);
    end
    #2;
    RST_N = 1'b0;
    #1;
    n_checks++; if (DE_VALID !== 1'b0 || MEM_READ1 !== 1'b0 || MEM_ADDR1 !== 32'h0) begin
      n_fail++; $display("FAIL areset_ctl valid=%h read=%h addr=%h exp 0 0 0", DE_VALID, MEM_READ1, MEM_ADDR1);
    end
    n_checks++; if (DE_PC !== 32'h0 || DE_IR !== 32'h0 || DE_PCPLUS4 !== 32'h4) begin
      n_fail++; $display("FAIL areset_head pc=%h ir=%h p4=%h exp 0 0 4", DE_PC, DE_IR, DE_PCPLUS4);
    end
    next_cycle();
    RST_N = 1'b1;
    @(negedge CLK);
    n_checks++; if (MEM_READ1 !== 1'b1 || MEM_ADDR1 !== 32'h0) begin
      n_fail++; $display("FAIL areset_resume read=%h addr=%h exp read=1 addr=0", MEM_READ1, MEM_ADDR1);
    end
    next_cycle();
    @(negedge CLK);
    n_checks++; if (DE_VALID !== 1'b0) begin n_fail++; $display("FAIL areset_gap valid=%h pc=%h exp valid=0", DE_VALID, DE_PC); end
    next_cycle();
    @(negedge CLK);
    n_checks++; if (DE_VALID !== 1'b1 || DE_PC !== 32'h0 || DE_IR !== c_KEY) begin
      n_fail++; $display("FAIL areset_head0 valid=%h pc=%h ir=%h exp valid=1 pc=0 ir=a5a5a5a5", DE_VALID, DE_PC, DE_IR);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_align();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
